axi_burst_reader: RTL
=====================

Name: axi_burst_reader

Overview:
AXI4 read-only initiator that fetches a linear range of memory from an AXI slave (e.g. the axi_mem model) and streams the returned data out on a ready/valid interface. A single start command (address, beat count) is split into INCR bursts of at most MAX_BURST beats. No burst crosses a 4 KB boundary. One burst is outstanding at a time. Used by benches and checkers to dump or compare memory contents.

Parameters:
ID_WD, 3, AXI ID width
ADDR_WD, 32, AXI address width
DATA_WD, 64, data width; legal values 8..512, power of 2; ADDR_LSB = log2(DATA_WD/8)
LEN_WD, 8, ARLEN width
CNT_WD, 16, width of the total beat count
MAX_BURST, 16, max beats per burst; 1..2^LEN_WD
ARID_VAL, 0, constant ID driven on ARID

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
start  in  1  command pulse; sampled only when busy=0
start_addr  in  ADDR_WD  start byte address; low ADDR_LSB bits ignored (aligned down)
num_beats  in  CNT_WD  total beats to read
busy  out  1  command in progress
done  out  1  one-cycle pulse when the command completes
err  out  1  sticky error for the current/last command
out_valid  out  1  read data valid
out_ready  in  1  consumer ready
out_data  out  DATA_WD  read data
out_last  out  1  final beat of the whole command
ARID  out  ID_WD  = ARID_VAL
ARADDR  out  ADDR_WD  burst address
ARLEN  out  LEN_WD  beats-1
ARSIZE  out  3  constant ADDR_LSB
ARBURST  out  2  constant 2'b01 (INCR)
ARVALID  out  1  address valid
ARREADY  in  1  address ready
RID  in  ID_WD  read ID
RDATA  in  DATA_WD  read data
RRESP  in  2  read response
RLAST  in  1  last beat of the burst
RVALID  in  1  read valid
RREADY  out  1  read ready

Behaviour:
- Reset: state IDLE. busy, done, err, ARVALID, RREADY, out_valid, out_last = 0. ARADDR/ARLEN = 0. ARSIZE/ARBURST keep their constants. Reset mid-command aborts: all outputs return to reset values on the next cycle.
- FSM states:
  - IDLE: on start, latch addr = start_addr aligned down, rem = num_beats, and clear err. If num_beats = 0, go to DONE; else go to REQ. busy = 1 from the cycle after start until the DONE cycle inclusive. A start while busy = 1 is ignored.
  - REQ: compute blen = min(rem, MAX_BURST, (4096 - addr[11:0]) >> ADDR_LSB). Drive ARADDR = addr, ARLEN = blen-1, ARVALID = 1. Hold these stable until ARREADY. On the handshake, go to DATA and set rem -= blen and bcnt = 0.
  - DATA: zero-latency passthrough. out_valid = RVALID, out_data = RDATA, RREADY = out_ready (RREADY = 0 in all other states). A beat transfers when RVALID & RREADY; each transfer does bcnt += 1. out_last = RVALID & (bcnt == ARLEN) & (rem == 0).
    - Burst end is determined by the counter (bcnt == ARLEN), not by RLAST.
    - At burst end: if rem = 0, go to DONE; else addr += blen << ADDR_LSB (modulo 2^ADDR_WD) and go to REQ.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Error flag (err set, data still forwarded, burst continues normally):
  - RRESP != 0 on any beat;
  - RID != ARID_VAL;
  - RLAST value differs from (bcnt == ARLEN).
  err stays valid through done and until the next accepted start.
- No beat is dropped or duplicated under any out_ready pattern; ordering is preserved.
- ARADDR never decreases within a command except on address-space wrap.

Test Plan:
- DATA_WD=64, start_addr=0x0, num_beats=4, slave always ready -> one AR (ARADDR=0x0, ARLEN=3, ARSIZE=3, ARBURST=1); 4 beats out in order; out_last on beat 4; done one cycle later; err=0.
- start_addr=0x100, num_beats=40 -> ARs (0x100,15), (0x180,15), (0x200,7); 40 beats; out_last only on beat 40.
- start_addr=0xFF0, num_beats=8 -> ARs (0xFF0,1), (0x1000,5); no burst crosses 0x1000.
- RVALID held high, out_ready alternating 1/0 -> RREADY mirrors out_ready; data sequence matches memory exactly; ARVALID stays stable under ARREADY=0 for 5 cycles.
- RRESP=2 on beat 2 of a 4-beat read -> all 4 beats forwarded, err=1 at done; next start clears err; missing RLAST on the last beat -> err=1.
- num_beats=0 -> done the cycle after start, ARVALID never asserted; start during busy ignored; ARESET during DATA -> busy/ARVALID/RREADY = 0 the next cycle, FSM in IDLE.

Source files
------------

// File: rtl/axi_burst_reader.sv
// AXI4 read initiator: splits a linear beat range into INCR bursts
// (4 KB safe, one outstanding) and streams the data out on ready/valid.
module axi_burst_reader #(
  parameter int ID_WD     = 3,
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 64,
  parameter int LEN_WD    = 8,
  parameter int CNT_WD    = 16,
  parameter int MAX_BURST = 16,
  parameter int ARID_VAL  = 0
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               start,
  input  logic [ADDR_WD-1:0] start_addr,
  input  logic [CNT_WD-1:0]  num_beats,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_WD-1:0] out_data,
  output logic               out_last,
  output logic [ID_WD-1:0]   ARID,
  output logic [ADDR_WD-1:0] ARADDR,
  output logic [LEN_WD-1:0]  ARLEN,
  output logic [2:0]         ARSIZE,
  output logic [1:0]         ARBURST,
  output logic               ARVALID,
  input  logic               ARREADY,
  input  logic [ID_WD-1:0]   RID,
  input  logic [DATA_WD-1:0] RDATA,
  input  logic [1:0]         RRESP,
  input  logic               RLAST,
  input  logic               RVALID,
  output logic               RREADY
);

  localparam int ADDR_LSB = $clog2(DATA_WD / 8);
  localparam logic [ADDR_WD-1:0] LSB_MASK =
    ADDR_WD'((1 << ADDR_LSB) - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DONE
  } state_t;

  state_t state;

  logic [ADDR_WD-1:0] addr;
  logic [ADDR_WD-1:0] addr_nxt;
  logic [ADDR_WD-1:0] start_al;
  logic [CNT_WD-1:0]  rem;
  logic [LEN_WD:0]    bl;
  logic [LEN_WD:0]    bl_nxt;
  logic [LEN_WD:0]    bl_start;
  logic [LEN_WD-1:0]  bcnt;
  logic               in_data;
  logic               beat;
  logic               bend;
  logic               bad;

  // Burst length limited by remaining beats, MAX_BURST and the 4 KB page.
  function automatic logic [LEN_WD:0] blen_f(
    input logic [11:0]       off,
    input logic [CNT_WD-1:0] r
  );
    logic [31:0] b;
    logic [31:0] pg;
    b = 32'(r);
    if (b > 32'(MAX_BURST))
      b = 32'(MAX_BURST);
    pg = (32'd4096 - {20'd0, off}) >> ADDR_LSB;
    if (pg < b)
      b = pg;
    return b[LEN_WD:0];
  endfunction

  assign ARID    = ID_WD'(ARID_VAL);
  assign ARSIZE  = 3'(ADDR_LSB);
  assign ARBURST = 2'b01;

  assign in_data   = (state == DATA);
  assign RREADY    = in_data & out_ready;
  assign out_valid = in_data & RVALID;
  assign out_data  = RDATA;
  assign bend      = (bcnt == ARLEN);
  assign out_last  = out_valid & bend & (rem == '0);
  assign beat      = RVALID & RREADY;
  assign bad       = (RRESP != 2'b00) | (RID != ARID) | (RLAST != bend);

  assign start_al = start_addr & ~LSB_MASK;
  assign bl_start = blen_f(start_al[11:0], num_beats);
  assign addr_nxt = addr + (ADDR_WD'(bl) << ADDR_LSB);
  assign bl_nxt   = blen_f(addr_nxt[11:0], rem);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      ARVALID <= 1'b0;
      ARADDR  <= '0;
      ARLEN   <= '0;
      addr    <= '0;
      rem     <= '0;
      bl      <= '0;
      bcnt    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            addr <= start_al;
            rem  <= num_beats;
            err  <= 1'b0;
            busy <= 1'b1;
            if (num_beats == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= REQ;
              ARVALID <= 1'b1;
              ARADDR  <= start_al;
              ARLEN   <= LEN_WD'(bl_start - 1'b1);
              bl      <= bl_start;
            end
          end
        end
        REQ: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            rem     <= rem - CNT_WD'(bl);
            bcnt    <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (bad)
              err <= 1'b1;
            bcnt <= bcnt + 1'b1;
            // Burst end comes from the beat counter, never from RLAST.
            if (bend) begin
              if (rem == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                addr    <= addr_nxt;
                ARADDR  <= addr_nxt;
                ARLEN   <= LEN_WD'(bl_nxt - 1'b1);
                bl      <= bl_nxt;
                ARVALID <= 1'b1;
                state   <= REQ;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
